// File: rtl/reg_arb_pkg.sv
// Shared types and sizing for the register write arbiter.
// Holds the FSM state enum, counter width and owner-width helper.
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      LOCKED = 2'd2
   } arb_state_e;

   // burst counter width; LOCK_MAX <= 15 keeps it from wrapping
   localparam int LCNT_W = 4;

   // owner/pointer index width for a given requester count
   function automatic int own_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int OWN_W_MAX = own_w(8);

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Ports: req (request vector), ptr (search start), valid (any req), winner (index).
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = own_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] winner
);

   always_comb begin
      int idx;
      idx    = 0;
      valid  = 1'b0;
      winner = '0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!valid && req[idx[W-1:0]]) begin
            valid  = 1'b1;
            winner = idx[W-1:0];
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter driving one storage register's enable/data, with bounded lock bursts.
// Ports: i_req/i_lock/i_data per requester in; o_ack, o_reg_en, o_reg_data, o_owner, o_busy out.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int LOCK_MAX = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [NUM_REQ-1:0]              i_req,
   input  logic [NUM_REQ-1:0]              i_lock,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  i_data,
   output logic [NUM_REQ-1:0]              o_ack,
   output logic                            o_reg_en,
   output logic [DATA_W-1:0]               o_reg_data,
   output logic [$clog2(NUM_REQ)-1:0]      o_owner,
   output logic                            o_busy
);

   localparam int OW = $clog2(NUM_REQ);

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic [OW-1:0]     ptr_q;
   logic [OW-1:0]     owner_q;
   logic [OW-1:0]     nxt_ptr;
   logic [OW-1:0]     win;
   logic [LCNT_W-1:0] lock_cnt_q;
   logic [DATA_W-1:0] data_q;
   logic              pick_valid;
   logic              lock_go;

   rr_pick #(
      .N (NUM_REQ),
      .W (OW)
   ) u_pick (
      .req    (i_req),
      .ptr    (ptr_q),
      .valid  (pick_valid),
      .winner (win)
   );

   // stay locked only while the burst still has room for another write
   assign lock_go = i_lock[owner_q] &&
                    (int'(lock_cnt_q) + 1 < LOCK_MAX);

   assign nxt_ptr = (owner_q == OW'(NUM_REQ - 1)) ?
                    '0 : owner_q + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_valid) state_d = WRITE;
         WRITE:   state_d = lock_go ? LOCKED : IDLE;
         LOCKED: begin
            if (i_req[owner_q])       state_d = WRITE;
            else if (!i_lock[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q      <= '0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         data_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  data_q  <= i_data[win];
                  owner_q <= win;
               end
            end
            WRITE: begin
               // pointer moves past the owner so a forced release
               // hands the next arbitration to someone else first
               ptr_q      <= nxt_ptr;
               lock_cnt_q <= lock_go ? lock_cnt_q + 1'b1 : '0;
            end
            LOCKED: begin
               if (i_req[owner_q])
                  data_q <= i_data[owner_q];
               else if (!i_lock[owner_q])
                  lock_cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_ack      = '0;
      o_reg_en   = 1'b0;
      o_reg_data = '0;
      if (state_q == WRITE) begin
         o_ack[owner_q] = 1'b1;
         o_reg_en       = 1'b1;
         o_reg_data     = data_q;
      end
      o_owner = owner_q;
      o_busy  = (state_q != IDLE);
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table plus write scoreboard.
// Drives requesters that drop or re-arm on ack; compares every register write.
module tb_reg_write_arbiter;

   logic            clk;
   logic            rst_n;
   logic [3:0]      req;
   logic [3:0]      lock;
   logic [3:0][7:0] data;
   logic [3:0]      ack;
   logic            reg_en;
   logic [7:0]      reg_data;
   logic [1:0]      owner;
   logic            busy;

   reg_write_arbiter #(
      .NUM_REQ  (4),
      .DATA_W   (8),
      .LOCK_MAX (4)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req),
      .i_lock     (lock),
      .i_data     (data),
      .o_ack      (ack),
      .o_reg_en   (reg_en),
      .o_reg_data (reg_data),
      .o_owner    (owner),
      .o_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] ack;
      logic [7:0] data;
      logic [1:0] own;
   } exp_t;

   typedef struct {
      logic [3:0] req;
      logic [7:0] data;
      logic [3:0] ack;
      logic [1:0] own;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[6];
   int   rem[4];
   int   n_vec;
   int   n_bad;
   int   n_acks;
   int   cyc_cnt;
   int   ack_cyc;

   task automatic chk(input string nm, input bit ok,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int idx, input logic [7:0] d);
      exp_t e;
      e.ack  = 4'(1 << idx);
      e.data = d;
      e.own  = 2'(idx);
      sb.push_back(e);
   endtask

   // negedge sampling: scoreboard pop plus requester reaction to ack
   task automatic mon();
      exp_t e;
      if (!rst_n) return;
      chk("ack_en_onehot",
          ((ack != 0) == reg_en) && ($countones(ack) <= 1),
          {27'd0, reg_en, ack}, {27'd0, reg_en, 4'h0});
      if (reg_en) begin
         n_acks++;
         ack_cyc = cyc_cnt;
         if (sb.size() == 0) begin
            chk("unexpected_write", 1'b0,
                {20'd0, ack, reg_data}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("write",
                ack == e.ack && reg_data == e.data && owner == e.own,
                {18'd0, owner, ack, reg_data},
                {18'd0, e.own, e.ack, e.data});
         end
         for (int j = 0; j < 4; j++) begin
            if (ack[j]) begin
               if (rem[j] > 0) begin
                  rem[j]--;
                  data[j] = data[j] + 8'd1;
               end else begin
                  req[j] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      cyc_cnt++;
   endtask

   task automatic wait_sb(input int lim);
      int k;
      k = 0;
      while (sb.size() != 0 && k < lim) begin
         tick();
         k++;
      end
      chk("drain", sb.size() == 0, sb.size(), 0);
      sb.delete();
      tick();
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      lock  = '0;
      for (int j = 0; j < 4; j++) rem[j] = 0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      int a0;
      int d;
      n_vec   = 0;
      n_bad   = 0;
      n_acks  = 0;
      cyc_cnt = 0;
      ack_cyc = 0;
      rst_n   = 1'b0;
      req     = '0;
      lock    = '0;
      data    = '0;
      for (int j = 0; j < 4; j++) rem[j] = 0;

      tbl[0] = '{req: 4'b0100, data: 8'hA5, ack: 4'b0100, own: 2'd2};
      tbl[1] = '{req: 4'b0001, data: 8'h01, ack: 4'b0001, own: 2'd0};
      tbl[2] = '{req: 4'b1000, data: 8'hFF, ack: 4'b1000, own: 2'd3};
      tbl[3] = '{req: 4'b0010, data: 8'h5A, ack: 4'b0010, own: 2'd1};
      tbl[4] = '{req: 4'b1000, data: 8'h00, ack: 4'b1000, own: 2'd3};
      tbl[5] = '{req: 4'b0001, data: 8'h80, ack: 4'b0001, own: 2'd0};

      // reset state
      repeat (2) tick();
      chk("rst_outputs",
          ack == 0 && !reg_en && reg_data == 0 && owner == 0 && !busy,
          {16'd0, busy, owner, reg_en, ack, reg_data}, 32'd0);
      do_reset();
      chk("post_rst_outputs",
          ack == 0 && !reg_en && reg_data == 0 && owner == 0 && !busy,
          {16'd0, busy, owner, reg_en, ack, reg_data}, 32'd0);

      // idle with no requests
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_no_en", !reg_en && !busy,
             {30'd0, busy, reg_en}, 32'd0);
      end

      // table of single requests with one-cycle latency check
      foreach (tbl[i]) begin
         data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
         for (int j = 0; j < 4; j++)
            if (tbl[i].req[j]) data[j] = tbl[i].data;
         req = tbl[i].req;
         push(int'(tbl[i].own), tbl[i].data);
         tick();
         chk("latency",
             reg_en && ack == tbl[i].ack && busy,
             {26'd0, busy, reg_en, ack},
             {26'd0, 1'b1, 1'b1, tbl[i].ack});
         wait_sb(10);
      end

      // four-way contention, each requester re-armed once
      do_reset();
      data = {8'hD0, 8'hC0, 8'hB0, 8'hA0};
      for (int j = 0; j < 4; j++) rem[j] = 1;
      for (int j = 0; j < 4; j++) push(j, data[j]);
      for (int j = 0; j < 4; j++) push(j, data[j] + 8'd1);
      req = 4'b1111;
      wait_sb(40);

      // lock burst by 1 with 3 contending; forced release after 4
      do_reset();
      data[1] = 8'h10;
      data[3] = 8'h3C;
      rem[1]  = 3;
      lock    = 4'b0010;
      for (int j = 0; j < 4; j++) push(1, 8'h10 + 8'(j));
      push(3, 8'h3C);
      req = 4'b1010;
      wait_sb(40);
      lock = '0;

      // lock drop by 0 after two writes; pending 2 served promptly
      do_reset();
      data[0] = 8'h40;
      data[2] = 8'h77;
      rem[0]  = 1;
      lock    = 4'b0001;
      push(0, 8'h40);
      push(0, 8'h41);
      push(2, 8'h77);
      a0  = n_acks;
      req = 4'b0101;
      k   = 0;
      while (n_acks < a0 + 2 && k < 40) begin
         tick();
         k++;
      end
      chk("lock_two_writes", n_acks == a0 + 2, n_acks - a0, 2);
      chk("locked_hold", busy && owner == 0 && !reg_en,
          {29'd0, busy, owner}, {29'd0, 1'b1, 2'd0});
      tick();
      tick();
      chk("locked_still", busy && !reg_en && owner == 0,
          {29'd0, busy, reg_en, 1'b0}, {29'd0, 1'b1, 2'd0});
      d    = cyc_cnt;
      lock = '0;
      wait_sb(10);
      chk("drop_latency", ack_cyc > d && ack_cyc - d <= 2,
          ack_cyc - d, 2);

      // async reset in the middle of a write cycle
      do_reset();
      data[2] = 8'h99;
      req     = 4'b0100;
      tick();
      chk("pre_rst_write", reg_en && ack == 4'b0100,
          {27'd0, reg_en, ack}, {27'd0, 1'b1, 4'b0100});
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_clear", !reg_en && ack == 0 && !busy,
          {26'd0, busy, reg_en, ack}, 32'd0);
      req = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("after_rst_idle", !busy && owner == 0,
          {29'd0, busy, owner}, 32'd0);
      data[1] = 8'h11;
      data[3] = 8'h33;
      push(1, 8'h11);
      push(3, 8'h33);
      req = 4'b1010;
      wait_sb(20);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
